// File: rtl/crypto1_enum_pkg.sv
// Crypto1 filter tables, controller state type and preimage helpers for candidate enumeration.
// The n-th preimage of a filter output is the n-th table index whose entry equals that output.
package crypto1_enum_pkg;

    localparam int          KEY_W    = 20;
    localparam int          CTR_W    = 15;
    localparam logic [14:0] CTR_LAST = 15'h7FFF;

    localparam logic [15:0] FA_TBL = 16'h9E98;
    localparam logic [15:0] FB_TBL = 16'hB48E;
    localparam logic [31:0] FC_TBL = 32'hEC57E80A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Each 4-input table has exactly eight preimages per output value, so a 3-bit n covers them.
    function automatic logic [3:0] f16_pre(input logic [15:0] tbl, input logic val,
                                           input logic [2:0] n);
        logic [3:0] r;
        logic [3:0] cnt;
        r   = '0;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i] == val) begin
                if (cnt == {1'b0, n}) r = i[3:0];
                cnt = cnt + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] f32_pre(input logic [31:0] tbl, input logic val,
                                           input logic [3:0] n);
        logic [4:0] r;
        logic [4:0] cnt;
        r   = '0;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            if (tbl[i] == val) begin
                if (cnt == {1'b0, n}) r = i[4:0];
                cnt = cnt + 5'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crypto1_b20_map.sv
// Combinational map from (keystream bit, Fc row, counter) to a 20-bit candidate state slice.
// Each nibble is a preimage chosen by counter bits, so distinct counters give distinct candidates.
module crypto1_b20_map
    import crypto1_enum_pkg::*;
(
    input  logic             i_bit,
    input  logic [3:0]       i_idx,
    input  logic [CTR_W-1:0] i_ctr,
    output logic [KEY_W-1:0] o_key20
);

    logic [4:0] w_sel;

    assign w_sel   = f32_pre(FC_TBL, i_bit, i_idx);
    assign o_key20 = {f16_pre(FA_TBL, w_sel[4], i_ctr[14:12]),
                      f16_pre(FB_TBL, w_sel[3], i_ctr[11:9]),
                      f16_pre(FA_TBL, w_sel[2], i_ctr[8:6]),
                      f16_pre(FA_TBL, w_sel[1], i_ctr[5:3]),
                      f16_pre(FB_TBL, w_sel[0], i_ctr[2:0])};

endmodule

// File: rtl/crypto1_enum_ctrl.sv
// Enumerates 32768 KEY20 candidates per accepted keystream bit; STAT_CNT counter under CRYPTO1_ENUM_STATS_EN.
// First candidate 1 cycle after bit accept, then 1/cycle; output register holds while OUT_READY is low.
module crypto1_enum_ctrl
    import crypto1_enum_pkg::*;
#(
    parameter logic [3:0] IDX = 4'd0
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        BIT_VALID,
    input  logic        BIT_IN,
    output logic        BIT_READY,
    input  logic        ABORT,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [19:0] KEY20,
    output logic        OUT_LAST,
    output logic        DONE,
    output logic [31:0] STAT_CNT
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CTR_W-1:0] r_ctr;
    logic             r_bit;
    logic             r_out_valid;
    logic             r_out_last;
    logic [KEY_W-1:0] r_key20;
    logic             r_done;

    logic             w_bit_hs;
    logic             w_load;
    logic             w_out_hs;
    logic             w_job_done;
    logic [KEY_W-1:0] w_key20;

    crypto1_b20_map u_map (
        .i_bit   (r_bit),
        .i_idx   (IDX),
        .i_ctr   (r_ctr),
        .o_key20 (w_key20)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // ABORT overrides every handshake, including one completing in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_hs    = 1'b0;
        w_load      = 1'b0;
        w_job_done  = 1'b0;
        w_out_hs    = r_out_valid & OUT_READY;
        if (ABORT) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (BIT_VALID) begin
                        w_bit_hs    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!r_out_valid || OUT_READY) begin
                        w_load = 1'b1;
                        if (r_ctr == CTR_LAST) w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_out_hs) begin
                        w_job_done  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_ctr       <= '0;
            r_bit       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_key20     <= '0;
            r_done      <= 1'b0;
        end else if (ABORT) begin
            r_ctr       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_job_done;
            if (w_bit_hs) begin
                r_bit <= BIT_IN;
                r_ctr <= '0;
            end
            if (w_load) begin
                r_key20     <= w_key20;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_ctr == CTR_LAST);
                r_ctr       <= r_ctr + 15'd1;
            end else if (w_job_done) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

`ifdef CRYPTO1_ENUM_STATS_EN
    logic [31:0] r_stat_cnt;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)       r_stat_cnt <= '0;
        else if (w_out_hs) r_stat_cnt <= r_stat_cnt + 32'd1;
    end

    assign STAT_CNT = r_stat_cnt;
`else
    assign STAT_CNT = '0;
`endif

    assign BIT_READY = (r_state == ST_IDLE);
    assign OUT_VALID = r_out_valid;
    assign OUT_LAST  = r_out_last;
    assign KEY20     = r_key20;
    assign DONE      = r_done;

endmodule

// File: tb/tb_crypto1_enum_ctrl.sv
// Directed and randomized bench for crypto1_enum_ctrl against a preimage-list reference model.
module tb_crypto1_enum_ctrl;

    localparam logic [3:0] TB_IDX = 4'd0;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        BIT_VALID = 1'b0;
    logic        BIT_IN = 1'b0;
    logic        ABORT = 1'b0;
    logic        OUT_READY = 1'b0;
    logic        BIT_READY;
    logic        OUT_VALID;
    logic        OUT_LAST;
    logic        DONE;
    logic [19:0] KEY20;
    logic [31:0] STAT_CNT;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int total_hs = 0;
    int first_key;
    int last_key;

    // Preimage lists straight from the zero/one sets of each filter table.
    int fa_set [2][8]  = '{'{0, 1, 2, 5, 6, 8, 13, 14}, '{3, 4, 7, 9, 10, 11, 12, 15}};
    int fb_set [2][8]  = '{'{0, 4, 5, 6, 8, 9, 11, 14}, '{1, 2, 3, 7, 10, 12, 13, 15}};
    int fc_set [2][16] = '{'{0, 2, 4, 5, 6, 7, 8, 9, 10, 12, 19, 21, 23, 24, 25, 28},
                           '{1, 3, 11, 13, 14, 15, 16, 17, 18, 20, 22, 26, 27, 29, 30, 31}};

    always #5 CLK = ~CLK;

    crypto1_enum_ctrl #(.IDX(TB_IDX)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .BIT_VALID (BIT_VALID),
        .BIT_IN    (BIT_IN),
        .BIT_READY (BIT_READY),
        .ABORT     (ABORT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .KEY20     (KEY20),
        .OUT_LAST  (OUT_LAST),
        .DONE      (DONE),
        .STAT_CNT  (STAT_CNT)
    );

    function automatic int model_key(input int b, input int idx, input int n);
        int sel;
        sel = fc_set[b][idx];
        return (fa_set[(sel >> 4) & 1][(n >> 12) & 7] << 16) |
               (fb_set[(sel >> 3) & 1][(n >> 9) & 7] << 12) |
               (fa_set[(sel >> 2) & 1][(n >> 6) & 7] << 8) |
               (fa_set[(sel >> 1) & 1][(n >> 3) & 7] << 4) |
                fb_set[sel & 1][n & 7];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Runs one full job; tied=1 holds OUT_READY high and checks exact timing.
    task automatic run_job(input logic b, input int rdy_pct, input bit tied);
        int          beats;
        int          done_at;
        int          t0;
        int          dups;
        int          seen [int];
        logic        pv, pr, pl;
        logic [19:0] pk;
        BIT_IN    = b;
        BIT_VALID = 1'b1;
        OUT_READY = 1'b1;
        chk("bit_ready_idle", BIT_READY, 1);
        tick();
        BIT_VALID = 1'b0;
        t0      = cyc;
        beats   = 0;
        done_at = -1;
        dups    = 0;
        for (int k = 0; k < (tied ? 33000 : 50000) && done_at < 0; k++) begin
            if (!tied) OUT_READY = ($urandom_range(99) < rdy_pct);
            pv = OUT_VALID;
            pr = OUT_READY;
            pk = KEY20;
            pl = OUT_LAST;
            tick();
            if (tied && cyc - t0 == 1) begin
                chk("first_valid", OUT_VALID, 1);
                chk("first_key_lat", KEY20, model_key(int'(b), TB_IDX, 0));
            end
            if (pv && pr) begin
                chk("key", pk, model_key(int'(b), TB_IDX, beats));
                chk("last", pl, (beats == 32767));
                if (seen.exists(int'(pk))) dups++;
                seen[int'(pk)] = 1;
                if (beats == 0) first_key = int'(pk);
                last_key = int'(pk);
                beats++;
                total_hs++;
            end else if (pv) begin
                chk("stall_valid", OUT_VALID, 1);
                chk("stall_key", KEY20, pk);
                chk("stall_last", OUT_LAST, pl);
            end
            if (DONE) done_at = cyc - t0;
        end
        chk("beats", beats, 32768);
        chk("dups", dups, 0);
        if (tied) chk("done_lat", done_at, 32769);
        else      chk("done_seen", (done_at >= 32769), 1);
        tick();
        chk("done_one_cycle", DONE, 0);
        chk("idle_after_job", BIT_READY, 1);
        chk("valid_after_job", OUT_VALID, 0);
    endtask

    initial begin
        logic b, b2;
        int   beats;
        int   done_cnt;
        logic pv;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_last", OUT_LAST, 0);
        chk("rst_done", DONE, 0);
        chk("rst_key", KEY20, 0);
        chk("rst_stat", STAT_CNT, 0);
        chk("rst_bit_ready", BIT_READY, 1);
        RESETn = 1'b1;
        tick();

        run_job(1'b0, 100, 1'b1);
        chk("job0_first", first_key, 32'h00000);
        chk("job0_last", last_key, 32'hEEEEE);

        run_job(1'b1, 80, 1'b0);
        chk("job1_first", first_key, 32'h00001);

`ifdef CRYPTO1_ENUM_STATS_EN
        chk("stat_two_jobs", STAT_CNT, 65536);
`else
        chk("stat_two_jobs", STAT_CNT, 0);
`endif

        // Abort concurrent with the handshake of beat 100.
        b         = 1'($urandom_range(1));
        BIT_IN    = b;
        BIT_VALID = 1'b1;
        OUT_READY = 1'b1;
        tick();
        BIT_VALID = 1'b0;
        beats     = 0;
        for (int k = 0; k < 200 && beats < 100; k++) begin
            pv = OUT_VALID;
            tick();
            if (pv) beats++;
        end
        chk("abort_pre_key", KEY20, model_key(int'(b), TB_IDX, 100));
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort_valid", OUT_VALID, 0);
        chk("abort_last", OUT_LAST, 0);
        chk("abort_ready", BIT_READY, 1);
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (DONE) done_cnt++;
            tick();
        end
        chk("abort_no_done", done_cnt, 0);

        b2        = 1'($urandom_range(1));
        BIT_IN    = b2;
        BIT_VALID = 1'b1;
        tick();
        BIT_VALID = 1'b0;
        tick();
        chk("restart_valid", OUT_VALID, 1);
        chk("restart_key", KEY20, model_key(int'(b2), TB_IDX, 0));

        // A bit offered during RUN must not disturb the job.
        BIT_VALID = 1'b1;
        BIT_IN    = ~b2;
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk("run_ignore_key", KEY20, model_key(int'(b2), TB_IDX, j));
            chk("run_bit_ready", BIT_READY, 0);
        end

        #2;
        RESETn = 1'b0;
        #1;
        chk("async_rst_valid", OUT_VALID, 0);
        chk("async_rst_key", KEY20, 0);
        chk("async_rst_last", OUT_LAST, 0);
        chk("async_rst_ready", BIT_READY, 1);
        chk("async_rst_stat", STAT_CNT, 0);
        BIT_VALID = 1'b0;
        RESETn    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_idle_valid", OUT_VALID, 0);
            chk("post_rst_idle_ready", BIT_READY, 1);
        end
        BIT_IN    = 1'b1;
        BIT_VALID = 1'b1;
        tick();
        BIT_VALID = 1'b0;
        tick();
        chk("post_rst_job_key", KEY20, model_key(1, TB_IDX, 0));
        chk("post_rst_job_valid", OUT_VALID, 1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/crypto1_enum_ctrl.md
CRYPTO1_ENUM_CTRL -- requirements
Module: crypto1_enum_ctrl

Interface
- REQ-001: Parameter `IDX`, default 4'd0, selects the Fc input-combination row (0..15) used for every job.
- REQ-002: `CLK`  in  1  single clock; all flops on its rising edge.
- REQ-003: `RESETn`  in  1  reset, asynchronous assert, active-low.
- REQ-004: `BIT_VALID`  in  1  keystream bit offered.
- REQ-005: `BIT_IN`  in  1  keystream output bit for the job.
- REQ-006: `BIT_READY`  out  1  controller accepts a bit; the handshake completes when `BIT_VALID` and `BIT_READY` are both high.
- REQ-007: `ABORT`  in  1  synchronous job cancel.
- REQ-008: `OUT_VALID`  out  1  a `KEY20` candidate is presented.
- REQ-009: `OUT_READY`  in  1  downstream accepts the candidate.
- REQ-010: `KEY20`  out  20  candidate 20-bit state slice.
- REQ-011: `OUT_LAST`  out  1  marks candidate 32767 of the job.
- REQ-012: `DONE`  out  1  one-cycle pulse when a job's last candidate is accepted.
- REQ-013: `STAT_CNT`  out  32  count of accepted candidates (see Configuration).

Function
- REQ-014: The controller SHALL have three states: IDLE, RUN and DRAIN.
- REQ-015: In IDLE, `BIT_READY` SHALL be 1; in all other states it SHALL be 0.
- REQ-016: On bit handshake in IDLE, the controller SHALL latch `BIT_IN`, clear the 15-bit counter `ctr` to 0, and go to RUN.
- REQ-017: The sel field SHALL be computed as sel = Fc[bit][IDX].
- REQ-018: Candidate mapping SHALL be {Fa[sel4][ctr14:12], Fb[sel3][ctr11:9], Fa[sel2][ctr8:6], Fa[sel1][ctr5:3], Fb[sel0][ctr2:0]}.
- REQ-019: Table contents SHALL be: Fa(0x9E98) zero-set {0,1,2,5,6,8,13,14}, one-set {3,4,7,9,10,11,12,15}.
- REQ-020: Fb(0xB48E) zero-set {0,4,5,6,8,9,11,14}, one-set {1,2,3,7,10,12,13,15}.
- REQ-021: Fc(0xEC57E80A) zero-set {0,2,4,5,6,7,8,9,10,12,19,21,23,24,25,28}, one-set {1,3,11,13,14,15,16,17,18,20,22,26,27,29,30,31}.
- REQ-022: In RUN, when `OUT_VALID`=0 or `OUT_READY`=1, the output register SHALL load the candidate for `ctr`, set `OUT_VALID`=1, set `OUT_LAST`=(`ctr`==0x7FFF), and increment `ctr`.
- REQ-023: Loading `ctr`=0x7FFF SHALL move the state to DRAIN with no further loads, so `ctr` wraps to 0 and is never reused.
- REQ-024: When `OUT_VALID`=1 and `OUT_READY`=0, `KEY20`, `OUT_LAST` and `OUT_VALID` SHALL hold stable.
- REQ-025: In DRAIN, on the output handshake the controller SHALL clear `OUT_VALID` and `OUT_LAST`, pulse `DONE` for exactly one cycle, and return to IDLE.
- REQ-026: Latency: with `OUT_READY` tied 1, the first candidate SHALL be valid 1 cycle after bit accept.
- REQ-027: With `OUT_READY` tied 1, the throughput SHALL be 1 candidate per cycle; `DONE` SHALL rise 32769 cycles after bit accept.
- REQ-028: The controller SHALL emit exactly 32768 candidates per job, all distinct, in `ctr` order.
- REQ-029: `ABORT` high in any state SHALL force IDLE on the next edge, clear `OUT_VALID`, `OUT_LAST` and `ctr`, and suppress `DONE`.
- REQ-030: `ABORT` SHALL take priority over a simultaneous bit or output handshake.
- REQ-031: `BIT_VALID` asserted outside IDLE SHALL be ignored, not queued.

Reset
- REQ-032: `RESETn` low SHALL asynchronously force IDLE, `ctr`=0, `OUT_VALID`=0, `OUT_LAST`=0, `DONE`=0, `KEY20`=0, `STAT_CNT`=0, latched bit=0; `BIT_READY` SHALL read 1 once in IDLE.
- REQ-033: Reset asserted mid-job SHALL discard the job; after deassertion the controller SHALL wait for a new bit.

Configuration
- REQ-034: With `CRYPTO1_ENUM_STATS_EN` defined, `STAT_CNT` SHALL increment by 1 on every output handshake, wrap at 2^32, clear only on reset, and not be cleared by `ABORT`.
- REQ-035: Without `CRYPTO1_ENUM_STATS_EN`, `STAT_CNT` SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
- REQ-036: Package `crypto1_enum_pkg` SHALL hold the Fa, Fb and Fc tables, the state enum, and localparams for widths (20, 15) and last-count 15'h7FFF.
- REQ-037: Combinational sub-module `crypto1_b20_map` (inputs: bit, IDX, ctr; output: key20) SHALL implement the mapping.
- REQ-038: The controller SHALL own all state, handshakes and the output register.

Verification
- REQ-039: IDX=0, BIT_IN=0, OUT_READY=1 -> first KEY20=0x00000; last KEY20=0xEEEEE with OUT_LAST=1; DONE 32769 cycles after accept; 32768 beats.
- REQ-040: IDX=0, BIT_IN=1 -> first KEY20=0x00001 (sel=1).
- REQ-041: Random OUT_READY stalls -> KEY20/OUT_VALID stable while stalled; 32768 unique candidates; no drops or duplicates.
- REQ-042: ABORT at beat 100, concurrent with an output handshake -> next cycle OUT_VALID=0, no DONE, BIT_READY=1; a new job restarts at ctr 0.
- REQ-043: RESETn low mid-RUN -> outputs reset immediately without a clock edge; BIT_VALID during RUN is ignored.
- REQ-044: With CRYPTO1_ENUM_STATS_EN, two full jobs -> STAT_CNT=65536; without the macro -> STAT_CNT=0.
